// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard-controller states, the x0 register index
// and the encodings the pipeline registers load when flushed.
package pipeline_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  localparam logic [4:0]  REG_ZERO     = 5'd0;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic        BUBBLE_VALID = 1'b0;

  // True when an ID source operand is both read and equal to the EX destination.
  function automatic logic src_match(input logic use_rs, input logic [4:0] rs,
                                     input logic [4:0] rd);
    return use_rs && (rs == rd);
  endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter with synchronous clear; wraps modulo 2^CNT_W.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: next-state is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline sequencing controller: memory-wait freeze, EX redirect flush and
// load-use bubble, plus stall/flush counters and a sticky memory-timeout flag.
module hazard_ctrl_unit
  import pipeline_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_MemRead,
  input  logic             EX_redirect,
  input  logic             MEM_req,
  input  logic             MEM_ready,
  input  logic             perf_clr,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_write,
  output logic             ID_EX_flush,
  output logic             EX_MEM_write,
  output logic             MEM_WB_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  hz_state_e       state_q;
  logic [TO_W-1:0] wait_cnt_q;
  logic            timeout_q;

  logic mem_busy, load_use, redirect, stall;

  assign mem_busy = MEM_req & ~MEM_ready;
  assign load_use = ID_EX_MemRead && (ID_EX_rd != REG_ZERO) &&
                    (src_match(ID_use_rs1, IF_ID_rs1, ID_EX_rd) ||
                     src_match(ID_use_rs2, IF_ID_rs2, ID_EX_rd));

  // Freeze dominates; a held EX/ID re-presents redirect and load-use on release.
  assign redirect = ~mem_busy & EX_redirect;
  assign stall    = mem_busy | (~EX_redirect & load_use);

  assign PC_write     = rstn & ~stall;
  assign IF_ID_write  = rstn & ~stall;
  assign IF_ID_flush  = rstn & redirect;
  assign ID_EX_write  = rstn & ~mem_busy;
  assign ID_EX_flush  = rstn & ~mem_busy & (EX_redirect | load_use);
  assign EX_MEM_write = rstn & ~mem_busy;
  assign MEM_WB_flush = rstn & mem_busy;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (perf_clr)
        timeout_q <= 1'b0;
      else if (state_q == MEM_WAIT && wait_cnt_q == TO_MAX && !MEM_ready)
        timeout_q <= 1'b1;

      case (state_q)
        RUN: begin
          if (mem_busy) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= TO_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_busy) begin
            if (wait_cnt_q != TO_MAX) wait_cnt_q <= wait_cnt_q + TO_W'(1);
          end else begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign mem_timeout = timeout_q;

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .en_i  (stall),
    .clr_i (perf_clr),
    .cnt_o (stall_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .en_i  (redirect),
    .clr_i (perf_clr),
    .cnt_o (flush_cnt)
  );

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Pipeline sequencing controller for the 5-stage RISC-V core. It sits beside the EX-stage operand-forwarding logic and covers the hazards forwarding cannot resolve: load-use dependencies, taken branches/jumps resolved in EX, and multi-cycle data-memory accesses. It drives the write-enable and flush controls of the PC and the four pipeline registers. It also keeps stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
CNT_W, 32, width of the performance counters (wrap on overflow)
TIMEOUT, 64, max MEM_WAIT cycles before mem_timeout sets (≥2)
TO_W, 7, width of the wait counter (must hold TIMEOUT)

Ports:
clk  in  1  core clock, rising edge
rstn  in  1  asynchronous active-low reset
IF_ID_rs1  in  5  rs1 field of instruction in ID
IF_ID_rs2  in  5  rs2 field of instruction in ID
ID_use_rs1  in  1  ID instruction reads rs1
ID_use_rs2  in  1  ID instruction reads rs2
ID_EX_rd  in  5  destination of instruction in EX
ID_EX_MemRead  in  1  EX instruction is a load
EX_redirect  in  1  branch taken or jump in EX (PC redirect)
MEM_req  in  1  MEM-stage instruction accesses data memory
MEM_ready  in  1  data memory completes access this cycle
perf_clr  in  1  synchronous clear of counters and mem_timeout
PC_write  out  1  PC register enable
IF_ID_write  out  1  IF/ID enable
IF_ID_flush  out  1  IF/ID loads NOP
ID_EX_write  out  1  ID/EX enable
ID_EX_flush  out  1  ID/EX loads bubble
EX_MEM_write  out  1  EX/MEM enable
MEM_WB_flush  out  1  MEM/WB loads bubble
stall_cnt  out  CNT_W  cycles with PC_write=0
flush_cnt  out  CNT_W  redirect flush events
mem_timeout  out  1  sticky: a wait exceeded TIMEOUT

Behaviour:
- Reset (rstn=0, async): state=RUN, wait counter=0, stall_cnt=0, flush_cnt=0, mem_timeout=0. While reset is asserted, all *_write=0 and all *_flush=0. Deasserting reset mid-operation resumes in RUN.
- Control outputs are combinational from state and inputs. Counters and the flag are registered.
- Terms: mem_busy = MEM_req & ~MEM_ready; load_use = ID_EX_MemRead & (ID_EX_rd≠0) & ((ID_use_rs1 & ID_EX_rd==IF_ID_rs1) | (ID_use_rs2 & ID_EX_rd==IF_ID_rs2)).
- Default (RUN, no hazard): all *_write=1, all *_flush=0.
- FSM states: RUN, MEM_WAIT.
  - RUN → MEM_WAIT when mem_busy; wait counter loads 1.
  - MEM_WAIT → RUN on the cycle MEM_ready=1.
- Freeze (mem_busy in either state): PC_write, IF_ID_write, ID_EX_write and EX_MEM_write all 0; MEM_WB_flush=1. This has top priority: EX_redirect and load_use are ignored while frozen and act on the release cycle, since EX and ID contents are held.
- Redirect (not frozen, EX_redirect=1): IF_ID_flush=1 and ID_EX_flush=1; PC_write=1 so PC takes the target; flush_cnt+1. Redirect beats load_use, because the dependent instruction is squashed.
- Load-use (not frozen, no redirect, load_use=1): PC_write=0, IF_ID_write=0, ID_EX_flush=1. Exactly one bubble; the next cycle the load sits in MEM and forwarding handles the dependency.
- Wait counter: increments each MEM_WAIT cycle and saturates at TIMEOUT. When a cycle in MEM_WAIT has count==TIMEOUT and MEM_ready=0, mem_timeout sets. The pipeline keeps waiting; there is no abort.
- stall_cnt increments every cycle PC_write=0 (freeze or load-use); flush_cnt increments per redirect cycle. Both wrap modulo 2^CNT_W.
- perf_clr: counters and mem_timeout go to 0 next edge and the same-cycle increment is dropped. The FSM is unaffected.
- MEM_ready=1 with MEM_req=0 is ignored.

Decomposition:
- Shared package (pipeline_pkg): state enum {RUN, MEM_WAIT}, the REG_ZERO=5'd0 constant, and the NOP/bubble encoding constants used by the pipeline registers.
- One natural sub-module: perf_counter (enable, clear, wrap; CNT_W parameter), instantiated twice.
- Hazard detection and the FSM stay in the top module.

Test Plan:
- Reset: rstn low mid-MEM_WAIT with stall_cnt=5 → all outputs 0, counters 0, state RUN; after release with no hazards, all writes=1.
- Load-use: lw x5 in EX (MemRead=1, rd=5), ID rs2=5 with use_rs2=1 → one cycle PC_write=0, IF_ID_write=0, ID_EX_flush=1, stall_cnt=1; next cycle normal. Repeat with rd=0 → no stall.
- Redirect + load-use same cycle: EX_redirect=1, load_use=1 → IF_ID_flush=ID_EX_flush=1, PC_write=1, flush_cnt=1, stall_cnt unchanged.
- Memory wait: MEM_req=1, MEM_ready low 3 cycles then high, EX_redirect=1 throughout → 3 freeze cycles (EX_MEM_write=0, MEM_WB_flush=1), stall_cnt=3; redirect flush on the release cycle, flush_cnt=1.
- Timeout: TIMEOUT=4, MEM_ready held low 6 cycles → mem_timeout=1 after the 4th wait cycle and stays set after ready; perf_clr → 0.
- Wrap: CNT_W=4, 17 load-use stalls → stall_cnt=1.
